mem_bist: RTL and testbench

MEM_BIST -- requirements
Module: mem_bist

---
 rtl/mem_bist_pkg.sv | 32 +++
 rtl/mem_bist_wdog.sv | 37 +++
 rtl/mem_bist.sv | 201 ++++++++++++++++++++
 tb/tb_mem_bist.sv | 300 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_bist_pkg.sv
// Shared types and defaults for the memory BIST engine: FSM encoding,
// bus request payload, default pattern seed and watchdog limit.
package mem_bist_pkg;

  localparam int unsigned ADDR_W = 32;
  localparam int unsigned DATA_W = 32;
  localparam int unsigned STRB_W = 4;
  localparam int unsigned CNT_W  = 16;

  localparam logic [DATA_W-1:0] DEFAULT_SEED    = 32'hA5A5_5A5A;
  localparam int unsigned       DEFAULT_TIMEOUT = 1023;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_WRITE = 2'd1,
    ST_READ  = 2'd2,
    ST_DONE  = 2'd3
  } state_e;

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
    logic [STRB_W-1:0] wstrb;
  } bus_req_t;

  // Test data stored at a byte address.
  function automatic logic [DATA_W-1:0] pattern(input logic [ADDR_W-1:0] a,
                                                input logic [DATA_W-1:0] seed);
    return a ^ seed;
  endfunction

endpackage

// File: rtl/mem_bist_wdog.sv
// Per-transaction watchdog: counts stalled cycles, flags when the limit is hit.
module mem_bist_wdog #(
  parameter int unsigned TIMEOUT = 1023
) (
  input  logic clk,
  input  logic resetn,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  logic [31:0] cnt_q, cnt_d;
  logic        expired_q, expired_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clear) begin
      cnt_d = '0;
    end else if (enable && (cnt_q != '1)) begin
      cnt_d = cnt_q + 32'd1;
    end
    expired_d = (cnt_d >= TIMEOUT);
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      cnt_q     <= '0;
      expired_q <= 1'b0;
    end else begin
      cnt_q     <= cnt_d;
      expired_q <= expired_d;
    end
  end

  assign expired = expired_q;

endmodule

// File: rtl/mem_bist.sv
// Memory BIST engine: writes an address-derived pattern over a word range on a
// picorv32-style native bus, reads it back, and reports pass/fail/timeout.
module mem_bist
  import mem_bist_pkg::*;
#(
  parameter logic [31:0] SEED    = DEFAULT_SEED,
  parameter int unsigned TIMEOUT = DEFAULT_TIMEOUT
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        start,
  input  logic [31:0] base_addr,
  input  logic [15:0] word_count,
  output logic        busy,
  output logic        done,
  output logic        pass,
  output logic        fail,
  output logic        timeout,
  output logic [31:0] err_addr,
  output logic [31:0] err_data,
  output logic        mem_valid,
  output logic        mem_instr,
  input  logic        mem_ready,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic [3:0]  mem_wstrb,
  input  logic [31:0] mem_rdata
);

  state_e            state_q, state_d;
  bus_req_t          req_q, req_d;
  logic              valid_q, valid_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic              pass_q, pass_d;
  logic              fail_q, fail_d;
  logic              timeout_q, timeout_d;
  logic [ADDR_W-1:0] err_addr_q, err_addr_d;
  logic [DATA_W-1:0] err_data_q, err_data_d;
  logic [ADDR_W-1:0] base_q, base_d;
  logic [CNT_W-1:0]  count_q, count_d;
  logic [CNT_W-1:0]  idx_q, idx_d;

  logic              hs_c, last_c, end_run_c, expired, wd_clear_c, wd_enable_c;
  logic [ADDR_W-1:0] next_addr_c;

  always_comb begin
    state_d    = state_q;
    req_d      = req_q;
    valid_d    = valid_q;
    busy_d     = busy_q;
    done_d     = 1'b0;
    pass_d     = pass_q;
    fail_d     = fail_q;
    timeout_d  = timeout_q;
    err_addr_d = err_addr_q;
    err_data_d = err_data_q;
    base_d     = base_q;
    count_d    = count_q;
    idx_d      = idx_q;
    end_run_c  = 1'b0;

    hs_c        = valid_q && mem_ready;
    last_c      = (idx_q == count_q - 16'd1);
    next_addr_c = req_q.addr + 32'd4;

    case (state_q)
      ST_IDLE: begin
        if (start) begin
          base_d     = base_addr & ~32'h3;
          count_d    = word_count;
          idx_d      = '0;
          pass_d     = 1'b0;
          fail_d     = 1'b0;
          timeout_d  = 1'b0;
          err_addr_d = '0;
          err_data_d = '0;
          if (word_count == '0) begin
            pass_d    = 1'b1;
            end_run_c = 1'b1;
          end else begin
            state_d = ST_WRITE;
            valid_d = 1'b1;
            busy_d  = 1'b1;
            req_d   = '{addr: base_d, wdata: pattern(base_d, SEED), wstrb: 4'hF};
          end
        end
      end
      ST_WRITE: begin
        if (hs_c) begin
          if (last_c) begin
            state_d = ST_READ;
            idx_d   = '0;
            req_d   = '{addr: base_q, wdata: '0, wstrb: 4'h0};
          end else begin
            idx_d = idx_q + 16'd1;
            req_d = '{addr: next_addr_c, wdata: pattern(next_addr_c, SEED), wstrb: 4'hF};
          end
        end else if (expired) begin
          fail_d     = 1'b1;
          timeout_d  = 1'b1;
          err_addr_d = req_q.addr;
          err_data_d = '0;
          end_run_c  = 1'b1;
        end
      end
      ST_READ: begin
        if (hs_c) begin
          if (mem_rdata != pattern(req_q.addr, SEED)) begin
            fail_d     = 1'b1;
            err_addr_d = req_q.addr;
            err_data_d = mem_rdata;
            end_run_c  = 1'b1;
          end else if (last_c) begin
            pass_d    = 1'b1;
            end_run_c = 1'b1;
          end else begin
            idx_d      = idx_q + 16'd1;
            req_d.addr = next_addr_c;
          end
        end else if (expired) begin
          fail_d     = 1'b1;
          timeout_d  = 1'b1;
          err_addr_d = req_q.addr;
          err_data_d = '0;
          end_run_c  = 1'b1;
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase

    // Common exit into DONE: drop the bus and pulse done.
    if (end_run_c) begin
      state_d     = ST_DONE;
      valid_d     = 1'b0;
      busy_d      = 1'b0;
      done_d      = 1'b1;
      req_d.wstrb = 4'h0;
    end

    wd_clear_c  = (state_d != state_q) || hs_c;
    wd_enable_c = valid_q && !mem_ready;
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q    <= ST_IDLE;
      req_q      <= '0;
      valid_q    <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      pass_q     <= 1'b0;
      fail_q     <= 1'b0;
      timeout_q  <= 1'b0;
      err_addr_q <= '0;
      err_data_q <= '0;
      base_q     <= '0;
      count_q    <= '0;
      idx_q      <= '0;
    end else begin
      state_q    <= state_d;
      req_q      <= req_d;
      valid_q    <= valid_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      pass_q     <= pass_d;
      fail_q     <= fail_d;
      timeout_q  <= timeout_d;
      err_addr_q <= err_addr_d;
      err_data_q <= err_data_d;
      base_q     <= base_d;
      count_q    <= count_d;
      idx_q      <= idx_d;
    end
  end

  mem_bist_wdog #(
    .TIMEOUT(TIMEOUT)
  ) u_wdog (
    .clk    (clk),
    .resetn (resetn),
    .clear  (wd_clear_c),
    .enable (wd_enable_c),
    .expired(expired)
  );

  assign busy      = busy_q;
  assign done      = done_q;
  assign pass      = pass_q;
  assign fail      = fail_q;
  assign timeout   = timeout_q;
  assign err_addr  = err_addr_q;
  assign err_data  = err_data_q;
  assign mem_valid = valid_q;
  assign mem_instr = 1'b0;
  assign mem_addr  = req_q.addr;
  assign mem_wdata = req_q.wdata;
  assign mem_wstrb = req_q.wstrb;

endmodule

// File: tb/tb_mem_bist.sv
// Scoreboard bench for mem_bist: a memory responder, a transaction-level
// reference model feeding expected queues, and a monitor that checks them.
module tb_mem_bist;

  logic        clk = 1'b0;
  logic        resetn, start;
  logic [31:0] base_addr;
  logic [15:0] word_count;
  logic        busy, done, pass, fail, timeout;
  logic [31:0] err_addr, err_data;
  logic        mem_valid, mem_instr, mem_ready;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic [3:0]  mem_wstrb;

  always #5 clk = ~clk;

  mem_bist #(.SEED(32'hA5A5_5A5A), .TIMEOUT(15)) dut (
    .clk(clk), .resetn(resetn), .start(start), .base_addr(base_addr),
    .word_count(word_count), .busy(busy), .done(done), .pass(pass),
    .fail(fail), .timeout(timeout), .err_addr(err_addr), .err_data(err_data),
    .mem_valid(mem_valid), .mem_instr(mem_instr), .mem_ready(mem_ready),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_wstrb(mem_wstrb),
    .mem_rdata(mem_rdata)
  );

  typedef struct {
    logic [31:0] addr;
    logic        we;
    logic [31:0] wdata;
  } txn_t;

  typedef struct {
    logic        pass;
    logic        fail;
    logic        timeout;
    logic [31:0] err_addr;
    logic [31:0] err_data;
  } res_t;

  txn_t        exp_q[$];
  res_t        res_q[$];
  logic [31:0] mem_model [logic [31:0]];

  int vec_cnt = 0;
  int err_cnt = 0;
  int cyc = 0;

  // responder controls
  int          resp_mode = 0;   // 0: always ready, 1: random waits, 2: never ready
  bit          corrupt_en = 1'b0;
  logic [31:0] corrupt_addr = '0;
  logic [31:0] corrupt_val = '0;

  // per-run observations
  bit done_seen;
  bit any_valid;
  int start_cyc, done_cyc, first_rd_cyc, last_rd_cyc;

  function automatic logic [31:0] model_pat(input logic [31:0] a);
    return a ^ 32'hA5A5_5A5A;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    vec_cnt++;
    if (act !== exp) begin
      err_cnt++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  initial forever @(posedge clk) cyc++;

  // Memory responder: drives ready/rdata on the falling edge.
  initial begin
    int wait_cnt;
    wait_cnt = 0;
    mem_ready = 1'b0;
    mem_rdata = '0;
    forever begin
      @(negedge clk);
      case (resp_mode)
        0: mem_ready = 1'b1;
        2: mem_ready = 1'b0;
        default: begin
          if (!mem_valid)        mem_ready = 1'($urandom_range(0, 1));
          else if (wait_cnt >= 3) mem_ready = 1'b1;
          else                   mem_ready = ($urandom_range(0, 2) == 0);
        end
      endcase
      if (mem_valid && !mem_ready) wait_cnt++;
      else                         wait_cnt = 0;
      if (mem_valid && mem_wstrb == 4'h0) begin
        if (corrupt_en && mem_addr == corrupt_addr) mem_rdata = corrupt_val;
        else if (mem_model.exists(mem_addr))       mem_rdata = mem_model[mem_addr];
        else                                        mem_rdata = 32'h0;
      end else begin
        mem_rdata = $urandom;
      end
    end
  end

  // Monitor: checks every handshake and every done pulse against the queues.
  initial begin
    bit          prev_stall, prev_done;
    logic [31:0] p_addr, p_wdata;
    logic [3:0]  p_wstrb;
    txn_t        t;
    res_t        r;
    prev_stall = 1'b0;
    prev_done  = 1'b0;
    p_addr = '0; p_wdata = '0; p_wstrb = '0;
    forever begin
      @(negedge clk);
      #2;
      if (!resetn) begin
        prev_stall = 1'b0;
        prev_done  = 1'b0;
      end else begin
        if (prev_stall && !done)
          chk("bus_hold", {27'd0, mem_valid, mem_wstrb, mem_addr},
              {27'd0, 1'b1, p_wstrb, p_addr});
        if (prev_stall && !done && mem_wstrb == 4'hF)
          chk("bus_hold_wdata", 64'(mem_wdata), 64'(p_wdata));
        if (mem_valid) any_valid = 1'b1;
        if (mem_valid && mem_ready) begin
          chk("txn_expected", 64'(exp_q.size() != 0), 64'd1);
          if (exp_q.size() != 0) begin
            t = exp_q.pop_front();
            chk("txn_addr", 64'(mem_addr), 64'(t.addr));
            chk("txn_strb", 64'(mem_wstrb), t.we ? 64'hF : 64'h0);
            chk("txn_instr", 64'(mem_instr), 64'd0);
            if (t.we) begin
              chk("txn_wdata", 64'(mem_wdata), 64'(t.wdata));
              mem_model[mem_addr] = mem_wdata;
            end else begin
              if (first_rd_cyc < 0) first_rd_cyc = cyc;
              last_rd_cyc = cyc;
            end
          end
        end
        if (done) begin
          if (!prev_done) begin
            chk("result_expected", 64'(res_q.size() != 0), 64'd1);
            if (res_q.size() != 0) begin
              r = res_q.pop_front();
              chk("res_flags", {61'd0, pass, fail, timeout}, {61'd0, r.pass, r.fail, r.timeout});
              chk("res_err_addr", 64'(err_addr), 64'(r.err_addr));
              chk("res_err_data", 64'(err_data), 64'(r.err_data));
              chk("done_bus_idle", {62'd0, busy, mem_valid}, 64'd0);
            end
            done_seen = 1'b1;
            done_cyc  = cyc;
          end else begin
            chk("done_single_cycle", 64'(done), 64'd0);
          end
        end
        prev_stall = mem_valid && !mem_ready;
        prev_done  = done;
        p_addr  = mem_addr;
        p_wdata = mem_wdata;
        p_wstrb = mem_wstrb;
      end
    end
  end

  // Reference model: expected bus transactions and final result of a run.
  task automatic prep(input logic [31:0] base, input logic [15:0] cnt, input int mode,
                      input bit corrupt, input int cidx, input logic [31:0] cval);
    logic [31:0] b, a;
    res_t        r;
    bit          failed;
    b = base & ~32'h3;
    exp_q.delete();
    res_q.delete();
    mem_model.delete();
    r = '{pass: 1'b1, fail: 1'b0, timeout: 1'b0, err_addr: 32'h0, err_data: 32'h0};
    if (cnt != 0 && mode == 2) begin
      r = '{pass: 1'b0, fail: 1'b1, timeout: 1'b1, err_addr: b, err_data: 32'h0};
    end else if (cnt != 0) begin
      for (int i = 0; i < int'(cnt); i++) begin
        a = b + 32'(4 * i);
        exp_q.push_back('{addr: a, we: 1'b1, wdata: model_pat(a)});
      end
      failed = 1'b0;
      for (int i = 0; i < int'(cnt) && !failed; i++) begin
        a = b + 32'(4 * i);
        exp_q.push_back('{addr: a, we: 1'b0, wdata: 32'h0});
        if (corrupt && i == cidx) begin
          failed = 1'b1;
          r = '{pass: 1'b0, fail: 1'b1, timeout: 1'b0, err_addr: a, err_data: cval};
        end
      end
    end
    res_q.push_back(r);
    resp_mode    = mode;
    corrupt_en   = corrupt;
    corrupt_addr = b + 32'(4 * cidx);
    corrupt_val  = cval;
    done_seen    = 1'b0;
    any_valid    = 1'b0;
    first_rd_cyc = -1;
    last_rd_cyc  = -1;
  endtask

  task automatic kick(input logic [31:0] base, input logic [15:0] cnt);
    @(negedge clk);
    base_addr  = base;
    word_count = cnt;
    start      = 1'b1;
    start_cyc  = cyc;
    @(posedge clk);
    #1;
    start = 1'b0;
  endtask

  task automatic wait_done();
    for (int i = 0; i < 3000 && !done_seen; i++) @(negedge clk);
    chk("done_within_budget", 64'(done_seen), 64'd1);
    repeat (3) @(negedge clk);
    chk("txn_queue_drained", 64'(exp_q.size()), 64'd0);
    chk("result_queue_drained", 64'(res_q.size()), 64'd0);
  endtask

  task automatic run(input logic [31:0] base, input logic [15:0] cnt, input int mode,
                     input bit corrupt, input int cidx, input logic [31:0] cval);
    prep(base, cnt, mode, corrupt, cidx, cval);
    kick(base, cnt);
    wait_done();
  endtask

  task automatic chk_reset_zero(input string name);
    chk(name, 64'(|{busy, done, pass, fail, timeout, err_addr, err_data, mem_valid,
                    mem_instr, mem_addr, mem_wdata, mem_wstrb}), 64'd0);
  endtask

  initial begin
    logic [31:0] b;
    logic [15:0] n;
    int          ci;
    resetn = 1'b0; start = 1'b0; base_addr = '0; word_count = '0;
    repeat (3) @(posedge clk);
    #1;
    chk_reset_zero("reset_state");
    @(negedge clk);
    resetn = 1'b1;

    // ready tied high, 4 words at 0x800
    run(32'h800, 16'd4, 0, 1'b0, 0, 32'h0);
    chk("t1_first_read_cyc", 64'(first_rd_cyc - start_cyc), 64'd5);
    chk("t1_last_read_cyc", 64'(last_rd_cyc - start_cyc), 64'd8);
    chk("t1_pass_sticky", {62'd0, pass, fail}, 64'd2);

    // corrupted read at 0x808
    run(32'h800, 16'd4, 0, 1'b1, 2, 32'h0);

    // stuck ready -> timeout
    run(32'h0000_4000, 16'd5, 2, 1'b0, 0, 32'h0);
    chk("to_done_latency", 64'((done_cyc - start_cyc == 16) || (done_cyc - start_cyc == 17)), 64'd1);

    // address wrap with random waits
    run(32'hFFFF_FFF8, 16'd3, 1, 1'b0, 0, 32'h0);

    // zero words
    run(32'h1234_5677, 16'd0, 0, 1'b0, 0, 32'h0);
    chk("zero_done_latency", 64'(done_cyc - start_cyc), 64'd1);
    chk("zero_no_valid", 64'(any_valid), 64'd0);

    // reset in the middle of the write phase, then a clean rerun
    prep(32'h0000_1000, 16'd8, 0, 1'b0, 0, 32'h0);
    kick(32'h0000_1000, 16'd8);
    repeat (2) @(negedge clk);
    resetn = 1'b0;
    @(posedge clk);
    #1;
    chk_reset_zero("mid_run_reset");
    @(negedge clk);
    resetn = 1'b1;
    exp_q.delete();
    res_q.delete();
    run(32'h0000_1000, 16'd8, 1, 1'b0, 0, 32'h0);

    // randomized runs
    for (int k = 0; k < 8; k++) begin
      b  = $urandom;
      n  = 16'($urandom_range(1, 12));
      ci = $urandom_range(0, int'(n) - 1);
      run(b, n, 1, ($urandom_range(0, 1) == 1), ci, $urandom ^ 32'h0000_0001);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL sim_time_limit: got no finish, required finish before limit");
    $fatal(1);
  end

endmodule
